// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage: bubble encoding, reset PC, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

  // addi x0,x0,0 -- the canonical RV32 bubble
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // 2'b11 is unused and recovers to FETCH
  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_WAIT    = 2'b01,
    S_DISCARD = 2'b10
  } if_state_t;

  // Redirect targets are word aligned; the low two bits are dropped
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: PC, PC+4, instruction and valid flag.
// Latency: 1 cycle from LOAD to outputs.
// Backpressure: HOLD freezes contents; FLUSH (highest priority) writes a bubble.
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD,
  input  logic        FLUSH,
  input  logic        HOLD,
  input  logic [31:0] PC_IN,
  input  logic [31:0] PC_4_IN,
  input  logic [31:0] INSTRUCTION_IN,
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  output logic [31:0] INSTRUCTION,
  output logic        VALID
);

  // Bubble on reset or flush, keep on hold, otherwise capture a fetched word
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC          <= 32'h0;
      PC_4        <= 32'h0;
      INSTRUCTION <= NOP_INSTR;
      VALID       <= 1'b0;
    end else if (FLUSH) begin
      PC          <= 32'h0;
      PC_4        <= 32'h0;
      INSTRUCTION <= NOP_INSTR;
      VALID       <= 1'b0;
    end else if (HOLD) begin
      PC          <= PC;
      PC_4        <= PC_4;
      INSTRUCTION <= INSTRUCTION;
      VALID       <= VALID;
    end else if (LOAD) begin
      PC          <= PC_IN;
      PC_4        <= PC_4_IN;
      INSTRUCTION <= INSTRUCTION_IN;
      VALID       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the I-cache, handles misses, redirects and stalls.
// Latency: hit word lands in IF/ID one cycle after its address is presented.
// Backpressure: IMEM_BUSYWAIT or HAZARD_STALL hold the PC; a miss cannot be aborted.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        HAZARD_STALL,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_INSTRUCTION,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_4,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic        IF_ID_VALID
);

  if_state_t   state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pending_target, pending_next;
  logic [31:0] pc_plus_4;
  logic [31:0] target;
  logic        ifid_load, ifid_flush, ifid_hold;

  assign pc_plus_4 = pc + 32'd4;
  assign target    = align_word(BRANCH_TARGET);
  assign IMEM_READ = ~RESET;
  // The PC is frozen throughout DISCARD, so it is also the in-flight old address
  assign IMEM_ADDRESS = pc;

  // PC, pending redirect and FSM state registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc             <= RESET_PC;
      pending_target <= 32'h0;
      state          <= S_FETCH;
    end else begin
      pc             <= pc_next;
      pending_target <= pending_next;
      state          <= state_next;
    end
  end

  // Next-state, next-PC and IF/ID control
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_target;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_hold    = 1'b0;
    case (state)
      S_FETCH, S_WAIT: begin
        if (IMEM_BUSYWAIT) begin
          if (BRANCH_TAKEN) begin
            pending_next = target;
            ifid_flush   = 1'b1;
            state_next   = S_DISCARD;
          end else begin
            ifid_flush   = ~HAZARD_STALL;
            ifid_hold    = HAZARD_STALL;
            state_next   = S_WAIT;
          end
        end else begin
          state_next = S_FETCH;
          if (BRANCH_TAKEN) begin
            pc_next    = target;
            ifid_flush = 1'b1;
          end else if (HAZARD_STALL) begin
            ifid_hold  = 1'b1;
          end else begin
            pc_next    = pc_plus_4;
            ifid_load  = 1'b1;
          end
        end
      end
      S_DISCARD: begin
        // The word returned for the abandoned fetch is never used
        ifid_flush = 1'b1;
        if (BRANCH_TAKEN) pending_next = target;
        if (!IMEM_BUSYWAIT) begin
          pc_next    = BRANCH_TAKEN ? target : pending_target;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .CLK            (CLK),
    .RESET          (RESET),
    .LOAD           (ifid_load),
    .FLUSH          (ifid_flush),
    .HOLD           (ifid_hold),
    .PC_IN          (pc),
    .PC_4_IN        (pc_plus_4),
    .INSTRUCTION_IN (IMEM_INSTRUCTION),
    .PC             (IF_ID_PC),
    .PC_4           (IF_ID_PC_4),
    .INSTRUCTION    (IF_ID_INSTRUCTION),
    .VALID          (IF_ID_VALID)
  );

endmodule
